if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline, directly upstream of the ID-stage control decoder. It holds the PC and fetches from instruction memory with a ready handshake. It presents the instruction and PC+4 to ID, and consumes the decoder's `shouldStall`, `shouldJumpOrBranch`, `jump` and `jumpRs` outputs to hold, redirect or bubble the front end.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `imem_addr` output 32: fetch address; always equals the current PC.
- `imem_req` output 1: fetch request.
- `imem_rdata` input 32: fetched word; valid only when `MIO_ready`=1.
- `MIO_ready` input 1: fetch-complete strobe for the current request.
- `shouldStall` input 1: from ID control; hold the PC and IF/ID.
- `shouldJumpOrBranch` input 1: from ID control; redirect.
- `jump` input 1: j/jal in ID.
- `jumpRs` input 1: jr in ID.
- `rsData` input 32: forwarded rs value, used as the jr target.
- `id_instruction` output 32: IF/ID instruction, feeds the ID decoder.
- `id_pcPlus4` output 32: IF/ID PC+4.
- `id_valid` output 1: IF/ID holds a real instruction (0 means bubble).
- `if_pc` output 32: current PC, for debug.

## Operation
- **Redirect:** redirect = `shouldJumpOrBranch` & `id_valid`.
- **Target selection,** priority jumpRs > jump > branch:
  - jumpRs: `rsData`.
  - jump: {`id_pcPlus4`[31:28], `id_instruction`[25:0], 2'b00}.
  - branch: `id_pcPlus4` + sign-extended `id_instruction`[15:0] shifted left 2.
  - All arithmetic is modulo 2^32; the PC wraps at 32'hFFFF_FFFC to 0 with no flag.
- **States:** FETCH (`imem_req`=1) and HELD (`imem_req`=0; a fetched word is parked in a 32-bit hold buffer).
- **FETCH transitions, evaluated in priority order:**
  - redirect: PC <= target, IF/ID <= bubble, stay FETCH.
  - `MIO_ready` & !`shouldStall`: IF/ID <= {`imem_rdata`, PC+4, valid=1}, PC <= PC+4.
  - `MIO_ready` & `shouldStall`: hold buffer <= `imem_rdata`, go HELD, PC and IF/ID unchanged.
  - !`MIO_ready` & !`shouldStall`: IF/ID <= bubble, PC unchanged.
  - !`MIO_ready` & `shouldStall`: everything held.
- **HELD transitions, evaluated in priority order:**
  - redirect: discard the hold buffer, PC <= target, IF/ID <= bubble, go FETCH.
  - !`shouldStall`: IF/ID <= {hold buffer, PC+4, valid=1}, PC <= PC+4, go FETCH.
  - `shouldStall`: stay HELD.
- **Bubble:** `id_instruction`=32'h0, `id_valid`=0, `id_pcPlus4` unchanged. The decoder treats 0 as a non-writing NOP.
- **Redirect vs stall:** redirect beats `shouldStall`. The decoder raises `shouldStall` together with `shouldJumpOrBranch`, and the front end must not deadlock on it.
- **Abandoned fetch:** on redirect during an outstanding request, `imem_addr` changes while `MIO_ready`=0. Instruction memory must accept the retargeted request and return data for the new address only.

## Timing
- **Reset values:** PC=`RESET_PC`, state FETCH, `imem_req`=1, `imem_addr`=`RESET_PC`, `id_instruction`=0, `id_pcPlus4`=0, `id_valid`=0, hold buffer=0. The same values apply immediately on `rst` assertion, including mid-fetch or in HELD.
- **Fetch latency:** a word accepted with `MIO_ready` on edge N appears in IF/ID after edge N. With a zero-wait memory the stage sustains 1 instruction per cycle.
- **Redirect latency:** the target appears on `imem_addr` one cycle after redirect is sampled. ID sees exactly one bubble, then the target instruction on the next edge with `MIO_ready`.
- **Combinational paths:** `imem_req` and `imem_addr` are decoded from registered state only. Target computation is combinational from IF/ID and `rsData`.

## Configuration
- `IF_PERF_CNT_EN` defined:
  - Adds outputs `perf_fetch_cnt` (32-bit), which increments on every IF/ID load with valid=1.
  - Adds `perf_bubble_cnt` (32-bit), which increments on every bubble load, including redirect bubbles.
  - Both counters are cleared by `rst` and wrap silently.
- Not defined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- **Zero-wait sequential fetch:** `RESET_PC`=0, `MIO_ready`=1, no stall → after 3 edges `id_pcPlus4`=12, `if_pc`=12, `id_valid`=1 each cycle.
- **Wait states:** `MIO_ready` low for 2 cycles → two bubbles (`id_valid`=0), PC fixed at 0, then `id_instruction`=word@0.
- **Stall in HELD:** `shouldStall` high 3 cycles with `MIO_ready`=1 → IF/ID frozen, `imem_req`=0 after the first edge. When the stall drops, the buffered word loads with no refetch.
- **Taken beq:** beq at 0x10 with imm=0xFFFC, redirect → `if_pc`=0x04 next cycle, one bubble, then word@0x04.
- **jr and jump priority:** jr with `rsData`=0x400 and `jump` also high → PC=0x400.
- **Reset mid-HELD:** assert `rst` → all outputs at reset values before the next edge.

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: bundles the instruction-memory handshake and the ID-stage
// control/IF-ID signals of the fetch stage.
//   master (fetch stage): drives imem_addr/imem_req, the IF/ID outputs, if_pc
//                         and, with IF_PERF_CNT_EN, the perf counters.
//   slave (memory + ID):  drives imem_rdata/MIO_ready and the ID control inputs.
// Optional feature macro: IF_PERF_CNT_EN (adds perf_fetch_cnt/perf_bubble_cnt).
interface if_fetch_stage_if;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic [31:0] imem_rdata;
   logic        MIO_ready;
   logic        shouldStall;
   logic        shouldJumpOrBranch;
   logic        jump;
   logic        jumpRs;
   logic [31:0] rsData;
   logic [31:0] id_instruction;
   logic [31:0] id_pcPlus4;
   logic        id_valid;
   logic [31:0] if_pc;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_bubble_cnt;

   modport master (
      output imem_addr, imem_req, id_instruction, id_pcPlus4, id_valid, if_pc,
             perf_fetch_cnt, perf_bubble_cnt,
      input  imem_rdata, MIO_ready, shouldStall, shouldJumpOrBranch, jump,
             jumpRs, rsData
   );
   modport slave (
      input  imem_addr, imem_req, id_instruction, id_pcPlus4, id_valid, if_pc,
             perf_fetch_cnt, perf_bubble_cnt,
      output imem_rdata, MIO_ready, shouldStall, shouldJumpOrBranch, jump,
             jumpRs, rsData
   );
`else
   modport master (
      output imem_addr, imem_req, id_instruction, id_pcPlus4, id_valid, if_pc,
      input  imem_rdata, MIO_ready, shouldStall, shouldJumpOrBranch, jump,
             jumpRs, rsData
   );
   modport slave (
      input  imem_addr, imem_req, id_instruction, id_pcPlus4, id_valid, if_pc,
      output imem_rdata, MIO_ready, shouldStall, shouldJumpOrBranch, jump,
             jumpRs, rsData
   );
`endif
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: MIPS instruction-fetch stage with the IF/ID pipeline register.
// Holds the PC, fetches through a ready handshake, parks a fetched word in a
// hold buffer while ID stalls, and redirects/bubbles on taken jumps/branches.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - if_fetch_stage_if.master (imem handshake, ID control, IF/ID outputs)
// Optional feature macro: IF_PERF_CNT_EN adds fetch/bubble performance counters.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   if_fetch_stage_if.master  bus
);
   localparam int unsigned XLEN = 32;

   typedef enum logic {
      S_FETCH = 1'b0,
      S_HELD  = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   hold_q, hold_d;
   logic [XLEN-1:0]   id_instr_q, id_instr_d;
   logic [XLEN-1:0]   id_pc4_q, id_pc4_d;
   logic              id_valid_q, id_valid_d;

   logic [XLEN-1:0]   pc_plus4;
   logic [XLEN-1:0]   br_off;
   logic [XLEN-1:0]   target;
   logic              redirect;
   logic              load_word;
   logic              load_bubble;
   logic [XLEN-1:0]   load_data;

   assign pc_plus4 = XLEN'(pc_q + XLEN'(4));
   assign br_off   = {{14{id_instr_q[15]}}, id_instr_q[15:0], 2'b00};
   // A bubble in IF/ID can never redirect, whatever the decoder drives.
   assign redirect = bus.shouldJumpOrBranch & id_valid_q;

   // Redirect target, priority jr > j > branch
   always_comb begin
      target = XLEN'(id_pc4_q + br_off);
      if (bus.jumpRs) begin
         target = bus.rsData;
      end else if (bus.jump) begin
         target = {id_pc4_q[31:28], id_instr_q[25:0], 2'b00};
      end
   end

   // Next state, PC, hold buffer and the IF/ID load decision
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      hold_d      = hold_q;
      load_word   = 1'b0;
      load_bubble = 1'b0;
      load_data   = bus.imem_rdata;
      case (state_q)
         S_FETCH: begin
            if (redirect) begin
               pc_d        = target;
               load_bubble = 1'b1;
            end else if (bus.MIO_ready && !bus.shouldStall) begin
               load_word = 1'b1;
               pc_d      = pc_plus4;
            end else if (bus.MIO_ready) begin
               hold_d  = bus.imem_rdata;
               state_d = S_HELD;
            end else if (!bus.shouldStall) begin
               load_bubble = 1'b1;
            end
         end
         S_HELD: begin
            if (redirect) begin
               pc_d        = target;
               load_bubble = 1'b1;
               state_d     = S_FETCH;
            end else if (!bus.shouldStall) begin
               load_word = 1'b1;
               load_data = hold_q;
               pc_d      = pc_plus4;
               state_d   = S_FETCH;
            end
         end
         default: state_d = S_FETCH;
      endcase
   end

   // IF/ID register update; a bubble keeps id_pcPlus4
   always_comb begin
      id_instr_d = id_instr_q;
      id_pc4_d   = id_pc4_q;
      id_valid_d = id_valid_q;
      if (load_word) begin
         id_instr_d = load_data;
         id_pc4_d   = pc_plus4;
         id_valid_d = 1'b1;
      end else if (load_bubble) begin
         id_instr_d = '0;
         id_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_FETCH;
         pc_q       <= RESET_PC;
         hold_q     <= '0;
         id_instr_q <= '0;
         id_pc4_q   <= '0;
         id_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         hold_q     <= hold_d;
         id_instr_q <= id_instr_d;
         id_pc4_q   <= id_pc4_d;
         id_valid_q <= id_valid_d;
      end
   end

   assign bus.imem_addr      = pc_q;
   assign bus.imem_req       = (state_q == S_FETCH);
   assign bus.id_instruction = id_instr_q;
   assign bus.id_pcPlus4     = id_pc4_q;
   assign bus.id_valid       = id_valid_q;
   assign bus.if_pc          = pc_q;

`ifdef IF_PERF_CNT_EN
   logic [XLEN-1:0] perf_fetch_q, perf_fetch_d;
   logic [XLEN-1:0] perf_bubble_q, perf_bubble_d;

   // Counters wrap silently
   always_comb begin
      perf_fetch_d  = perf_fetch_q;
      perf_bubble_d = perf_bubble_q;
      if (load_word) begin
         perf_fetch_d = XLEN'(perf_fetch_q + XLEN'(1));
      end
      if (load_bubble) begin
         perf_bubble_d = XLEN'(perf_bubble_q + XLEN'(1));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetch_q  <= '0;
         perf_bubble_q <= '0;
      end else begin
         perf_fetch_q  <= perf_fetch_d;
         perf_bubble_q <= perf_bubble_d;
      end
   end

   assign bus.perf_fetch_cnt  = perf_fetch_q;
   assign bus.perf_bubble_cnt = perf_bubble_q;
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: scoreboard bench for if_fetch_stage. The stimulus process
// drives one cycle of inputs and queues the hand-computed IF/ID and PC state
// expected after that edge; a monitor pops and compares on each falling edge
// (or on an immediate-check pulse for the asynchronous reset case).
module tb_if_fetch_stage;
   typedef struct {
      string       nm;
      logic        v;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic [31:0] pc;
      logic        req;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic chk = 1'b0;
   int   n_cmp  = 0;
   int   n_fail = 0;
   exp_t sb_q[$];

   if_fetch_stage_if bus ();

   if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Instruction memory contents
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0010: return 32'h1000_FFFC;  // beq $0,$0,-4
         32'h0000_0020: return 32'h0800_0010;  // j 0x40
         32'h0000_0040: return 32'h03E0_0008;  // jr $ra
         default:       return 32'hC0DE_0000 | {16'h0000, a[15:0]};
      endcase
   endfunction

   assign bus.imem_rdata = mem_word(bus.imem_addr);

   task automatic cmp32(input string nm, input string f,
                        input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got %h expected %h", nm, f, act, exp);
      end
   endtask

   // Monitor / scoreboard checker
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or posedge chk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            cmp32(e.nm, "id_valid",       32'(bus.id_valid),    32'(e.v));
            cmp32(e.nm, "id_instruction", bus.id_instruction,   e.instr);
            cmp32(e.nm, "id_pcPlus4",     bus.id_pcPlus4,       e.pc4);
            cmp32(e.nm, "if_pc",          bus.if_pc,            e.pc);
            cmp32(e.nm, "imem_addr",      bus.imem_addr,        e.pc);
            cmp32(e.nm, "imem_req",       32'(bus.imem_req),    32'(e.req));
         end
      end
   end

   task automatic push_exp(input string nm, input logic ev, input logic [31:0] ei,
                           input logic [31:0] ep4, input logic [31:0] epc,
                           input logic ereq);
      exp_t e;
      e.nm = nm; e.v = ev; e.instr = ei; e.pc4 = ep4; e.pc = epc; e.req = ereq;
      sb_q.push_back(e);
   endtask

   // One clock of stimulus plus the expected post-edge state
   task automatic cyc(input logic rdy, input logic st, input logic jb,
                      input logic j, input logic jr, input logic [31:0] rs,
                      input string nm, input logic ev, input logic [31:0] ei,
                      input logic [31:0] ep4, input logic [31:0] epc,
                      input logic ereq);
      bus.MIO_ready          = rdy;
      bus.shouldStall        = st;
      bus.shouldJumpOrBranch = jb;
      bus.jump               = j;
      bus.jumpRs             = jr;
      bus.rsData             = rs;
      push_exp(nm, ev, ei, ep4, epc, ereq);
      @(negedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.MIO_ready = 1'b0; bus.shouldStall = 1'b0; bus.shouldJumpOrBranch = 1'b0;
      bus.jump = 1'b0; bus.jumpRs = 1'b0; bus.rsData = 32'h0;
      push_exp("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      #1;
      rst = 1'b0;

      // zero-wait sequential fetch
      cyc(1,0,0,0,0,32'h0, "seq0", 1, 32'hC0DE_0000, 32'h4, 32'h4, 1);
      cyc(1,0,0,0,0,32'h0, "seq1", 1, 32'hC0DE_0004, 32'h8, 32'h8, 1);
      cyc(1,0,0,0,0,32'h0, "seq2", 1, 32'hC0DE_0008, 32'hC, 32'hC, 1);
      // wait states
      cyc(0,0,0,0,0,32'h0, "wait0", 0, 32'h0, 32'hC, 32'hC, 1);
      cyc(0,0,0,0,0,32'h0, "wait1", 0, 32'h0, 32'hC, 32'hC, 1);
      cyc(1,0,0,0,0,32'h0, "wait_done", 1, 32'hC0DE_000C, 32'h10, 32'h10, 1);
      // stall with data parked in the hold buffer; release with MIO_ready low
      cyc(1,1,0,0,0,32'h0, "stall0", 1, 32'hC0DE_000C, 32'h10, 32'h10, 0);
      cyc(1,1,0,0,0,32'h0, "stall1", 1, 32'hC0DE_000C, 32'h10, 32'h10, 0);
      cyc(1,1,0,0,0,32'h0, "stall2", 1, 32'hC0DE_000C, 32'h10, 32'h10, 0);
      cyc(0,0,0,0,0,32'h0, "unstall", 1, 32'h1000_FFFC, 32'h14, 32'h14, 1);
      // taken beq (with stall also high): 0x14 - 0x10 = 0x4
      cyc(1,1,1,0,0,32'h0, "beq_redir", 0, 32'h0, 32'h14, 32'h4, 1);
      cyc(1,0,0,0,0,32'h0, "beq_target", 1, 32'hC0DE_0004, 32'h8, 32'h8, 1);
      for (int a = 8; a <= 32'h20; a += 4) begin
         cyc(1,0,0,0,0,32'h0, "seq_run", 1, mem_word(32'(a)), 32'(a + 4), 32'(a + 4), 1);
      end
      // j 0x40
      cyc(1,0,1,1,0,32'h0, "j_redir", 0, 32'h0, 32'h24, 32'h40, 1);
      cyc(1,0,0,0,0,32'h0, "j_target", 1, 32'h03E0_0008, 32'h44, 32'h44, 1);
      // jr beats jump
      cyc(1,0,1,1,1,32'h400, "jr_redir", 0, 32'h0, 32'h44, 32'h400, 1);
      cyc(1,0,0,0,0,32'h0, "jr_target", 1, 32'hC0DE_0400, 32'h404, 32'h404, 1);
      // redirect request against a bubble is ignored
      cyc(0,0,0,0,0,32'h0, "bubble", 0, 32'h0, 32'h404, 32'h404, 1);
      cyc(1,0,1,0,0,32'h0, "redir_ignored", 1, 32'hC0DE_0404, 32'h408, 32'h408, 1);
      // PC wrap
      cyc(1,0,1,0,1,32'hFFFF_FFFC, "jr_wrap", 0, 32'h0, 32'h408, 32'hFFFF_FFFC, 1);
      cyc(1,0,0,0,0,32'h0, "wrap_fetch", 1, 32'hC0DE_FFFC, 32'h0, 32'h0, 1);
      // redirect out of HELD: 0 + (-16) wraps to 0xFFFFFFF0
      cyc(1,1,0,0,0,32'h0, "held_enter", 1, 32'hC0DE_FFFC, 32'h0, 32'h0, 0);
      cyc(1,1,1,0,0,32'h0, "held_redir", 0, 32'h0, 32'h0, 32'hFFFF_FFF0, 1);
      cyc(1,0,0,0,0,32'h0, "neg_target", 1, 32'hC0DE_FFF0, 32'hFFFF_FFF4, 32'hFFFF_FFF4, 1);
      cyc(0,1,0,0,0,32'h0, "full_hold", 1, 32'hC0DE_FFF0, 32'hFFFF_FFF4, 32'hFFFF_FFF4, 1);
      cyc(1,1,0,0,0,32'h0, "held_again", 1, 32'hC0DE_FFF0, 32'hFFFF_FFF4, 32'hFFFF_FFF4, 0);
      // asynchronous reset while HELD, checked before the next edge
      rst = 1'b1;
      #1;
      push_exp("rst_async", 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      chk = 1'b1;
      #1;
      chk = 1'b0;
      cyc(1,1,0,0,0,32'h0, "rst_hold", 0, 32'h0, 32'h0, 32'h0, 1);
      rst = 1'b0;
      cyc(1,0,0,0,0,32'h0, "post_rst", 1, 32'hC0DE_0000, 32'h4, 32'h4, 1);

      #1;
      while (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         n_fail++;
         $display("FAIL %s.unchecked: got none expected comparison", e.nm);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
